// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial two's-complement subtractor. Computes A - B one bit
//            per clock as A + ~B + 1 through a single full-adder cell and a
//            registered carry, with a START/BUSY/DONE handshake. Result and
//            flags are registered and held until the next completion.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y,
    output logic             BORROW,
    output logic             OVERFLOW,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // Counter value of the edge that processes the MSB
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_sa;        // minuend, shifted right each bit
    logic [WIDTH-1:0] r_sb;        // inverted subtrahend, shifted right
    logic [WIDTH-2:0] r_res;       // partially assembled difference
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_or;        // OR of all sum bits produced so far

    logic [WIDTH-1:0] r_y;
    logic             r_borrow;
    logic             r_ovf;
    logic             r_zero;

    logic             w_a;
    logic             w_b;
    logic             w_s;
    logic             w_cout;
    logic             w_last;
    logic             w_accept;
    logic             w_busy;
    logic             w_done;
    logic [WIDTH-1:0] w_res_next;

    // Full-adder cell on the current LSBs; the new sum bit enters at the MSB
    assign w_a        = r_sa[0];
    assign w_b        = r_sb[0];
    assign w_s        = w_a ^ w_b ^ r_carry;
    assign w_cout     = (w_a & w_b) | (w_a & r_carry) | (w_b & r_carry);
    assign w_last     = (r_cnt == c_LAST);
    assign w_res_next = {w_s, r_res};

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake decode; START is honoured in IDLE and FIN only
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next_state = S_FIN;
                end
            end
            S_FIN: begin
                w_done = 1'b1;
                if (START) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand capture and one-bit-per-cycle datapath
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_or    <= 1'b0;
        end else if (w_accept) begin
            r_sa    <= A;
            r_sb    <= ~B;
            r_carry <= 1'b1;          // the +1 of the two's complement
            r_cnt   <= '0;
            r_or    <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_sa    <= r_sa >> 1;
            r_sb    <= r_sb >> 1;
            r_res   <= w_res_next[WIDTH-1:1];
            r_carry <= w_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_or    <= r_or | w_s;
        end
    end

    // Result and flags update only on the edge that finishes the MSB;
    // r_carry at that point is the carry into the MSB
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_y      <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_y      <= w_res_next;
            r_borrow <= ~w_cout;
            r_ovf    <= r_carry ^ w_cout;
            r_zero   <= ~(r_or | w_s);
        end
    end

    assign Y        = r_y;
    assign BORROW   = r_borrow;
    assign OVERFLOW = r_ovf;
    assign ZERO     = r_zero;
    assign BUSY     = w_busy;
    assign DONE     = w_done;

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor: computes A - B one bit per clock as A + ~B + 1, through a single full-adder cell and a registered carry. It is the inverse-direction companion to the combinational ripple adder. It gives the ALU a low-area SUB path that runs with a START/DONE handshake. Results and flags are registered and held until the next operation completes.

Parameters:
WIDTH, 32, operand/result width in bits (matches the data path width from prj_definition.v); legal range 2..64
CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH

Ports:
CLK  input  1  clock, rising-edge active
RST  input  1  reset, asynchronous, active-high
START  input  1  request; sampled on a rising edge while the block is not BUSY
A  input  WIDTH  minuend; captured on the accepting edge only
B  input  WIDTH  subtrahend; captured on the accepting edge only
Y  output  WIDTH  difference A - B, modulo 2^WIDTH
BORROW  output  1  1 when A < B (unsigned), i.e. inverted final carry-out
OVERFLOW  output  1  signed overflow: carry into MSB XOR carry out of MSB
ZERO  output  1  1 when Y == 0
BUSY  output  1  1 while a subtraction is in progress
DONE  output  1  one-cycle pulse; Y and all flags are valid and newly updated

Behaviour:
- Reset (RST=1, asynchronous): state=IDLE; Y=0, BORROW=0, OVERFLOW=0, ZERO=0, BUSY=0, DONE=0; shift registers, carry and counter all cleared.
- Reset mid-operation: the operation is abandoned and no DONE is produced. After RST deasserts, the block is IDLE.
- States:
  - IDLE: waits for START.
  - RUN: processes one bit per cycle.
  - FIN: presents the result for one cycle.
- IDLE/FIN -> RUN: START=1 at edge t0.
  - Latch A into shift register SA and ~B into shift register SB.
  - Carry := 1.
  - Counter := 0.
  - Running-OR := 0.
  - BUSY=1 after t0.
- START is ignored in RUN; it is accepted in FIN, which permits back-to-back operations.
- RUN, edge t0+1+i (i = 0..WIDTH-1), using a = SA[0], b = SB[0], c = carry:
  - Sum bit s = a ^ b ^ c.
  - carry := majority(a, b, c).
  - s is shifted into the result register at the MSB end.
  - SA and SB shift right.
  - Running-OR |= s.
  - Counter increments.
  - When i = WIDTH-1, the carry-in c is saved as cmsb.
- RUN -> FIN: on edge t0+WIDTH, the edge that processes bit WIDTH-1.
  - Y := completed result.
  - BORROW := ~final carry.
  - OVERFLOW := cmsb ^ final carry.
  - ZERO := ~(running-OR | s).
  - BUSY=0, DONE=1.
- FIN -> IDLE: on the next edge if START=0, with DONE returning to 0.
- Outputs:
  - Y and the flags change only on the FIN-entry edge.
  - While RUN is in progress, they hold the previous result.
- Latency: DONE is high in the cycle after edge t0+WIDTH, i.e. WIDTH edges after the accepting edge. Throughput is one result per WIDTH+1 cycles back-to-back (accepting edge + WIDTH bit edges; START accepted in FIN).
- A and B may change freely after the accepting edge without affecting the operation.

Test Plan:
- A=5, B=3 (WIDTH=32) -> DONE exactly 32 edges after START; Y=0x00000002, BORROW=0, OVERFLOW=0, ZERO=0; BUSY high for 32 cycles.
- A=3, B=5 -> Y=0xFFFFFFFE, BORROW=1, OVERFLOW=0, ZERO=0.
- A=0x80000000, B=1 -> Y=0x7FFFFFFF, OVERFLOW=1, BORROW=0; A=0x7FFFFFFF, B=0xFFFFFFFF -> Y=0x80000000, OVERFLOW=1, BORROW=1.
- A=7, B=7 -> Y=0, ZERO=1, BORROW=0; then A=0, B=0 back-to-back with START held through FIN -> second DONE 32 edges after FIN; Y=0, ZERO=1.
- START pulsed again at cycle 10 of RUN with A=9, B=1 -> ignored; original result delivered; only one DONE pulse.
- RST asserted at cycle 15 of RUN, asynchronously mid-cycle -> all outputs 0 immediately, no DONE; then A=1, B=2 -> Y=0xFFFFFFFF, BORROW=1.
